// File: rtl/pp_stream_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : pp_stream_gen_if
//  Purpose  : Operand handshake and partial-product stream bundle for
//             pp_stream_gen. The master modport is the operand source and
//             pp sink; the slave modport is the generator itself.
//  Revision : 1.0  initial release
// ============================================================================
interface pp_stream_gen_if #(
  parameter int W  = 16,
  parameter int IW = 4
);
  localparam int PPW = W + 2;

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;
  logic           pp_valid;
  logic           pp_ready;
  logic [PPW-1:0] pp;
  logic           pp_neg;
  logic [IW-1:0]  pp_idx;
  logic           pp_last;

  modport master (
    output in_valid, in_x, in_y, pp_ready,
    input  in_ready, pp_valid, pp, pp_neg, pp_idx, pp_last
  );

  modport slave (
    input  in_valid, in_x, in_y, pp_ready,
    output in_ready, pp_valid, pp, pp_neg, pp_idx, pp_last
  );
endinterface
`default_nettype wire

// File: rtl/pp_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pp_stream_gen
//  Purpose  : Sequential partial-product generator. Captures one x/y pair and
//             streams one partial product per cycle (binary bit-select or
//             radix-4 Booth digits, signed or unsigned operands).
//  Revision : 1.0  initial release
// ============================================================================
module pp_stream_gen #(
  parameter int W      = 16,
  parameter bit RADIX4 = 1'b1,
  parameter bit SIGNED = 1'b1,
  localparam int PPW   = W + 2,
  localparam int NPP   = RADIX4 ? (SIGNED ? W / 2 : W / 2 + 1) : W,
  localparam int IW    = (NPP > 1) ? $clog2(NPP) : 1
) (
  input  logic             clk,
  input  logic             rst,
  pp_stream_gen_if.slave   strm
);

  if (RADIX4 && (W % 2 != 0)) begin : g_w_check
    $error("pp_stream_gen: W must be even when RADIX4=1");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic           valid_q, valid_d;
  logic [PPW-1:0] pp_q, pp_d;
  logic           neg_q, neg_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           last_q, last_d;

  logic           w_in_ready;
  logic           w_accept;
  logic           w_fire;
  logic [W-1:0]   w_gx;
  logic [W-1:0]   w_gy;
  logic [IW-1:0]  w_gidx;
  logic           w_glast;
  logic [PPW-1:0] w_ye;
  logic [PPW-1:0] w_pp;
  logic           w_neg;

  // A new pair may enter while idle, or in the same cycle the last pp leaves.
  assign w_in_ready = (state_q == ST_IDLE) || (valid_q && strm.pp_ready && last_q);
  assign w_accept   = strm.in_valid && w_in_ready;
  assign w_fire     = valid_q && strm.pp_ready;

  // The generator looks at the incoming pair when a new op starts, otherwise
  // at the stored pair and the next index.
  assign w_gx    = w_accept ? strm.in_x : x_q;
  assign w_gy    = w_accept ? strm.in_y : y_q;
  assign w_gidx  = w_accept ? '0 : idx_q + IW'(1);
  assign w_glast = (w_gidx == IW'(NPP - 1));
  assign w_ye    = SIGNED ? {{2{w_gy[W-1]}}, w_gy} : {2'b00, w_gy};

  if (RADIX4) begin : g_radix4
    logic [W+2:0]   w_xe;
    logic [2:0]     w_tri;
    logic [PPW-1:0] w_mag;
    logic           w_dneg;

    // Booth window {xe[2i+1], xe[2i], xe[2i-1]} with an implicit zero below bit 0.
    assign w_xe  = {(SIGNED ? {2{w_gx[W-1]}} : 2'b00), w_gx, 1'b0};
    assign w_tri = w_xe[{w_gidx, 1'b0} +: 3];

    // Decode the Booth digit into a magnitude (0, Y or 2Y) and a sign.
    always_comb begin
      w_mag  = '0;
      w_dneg = 1'b0;
      case (w_tri)
        3'b001, 3'b010: w_mag = w_ye;
        3'b011:         w_mag = w_ye << 1;
        3'b100: begin
          w_mag  = w_ye << 1;
          w_dneg = 1'b1;
        end
        3'b101, 3'b110: begin
          w_mag  = w_ye;
          w_dneg = 1'b1;
        end
        default: begin
          w_mag  = '0;
          w_dneg = 1'b0;
        end
      endcase
    end

    assign w_pp  = w_dneg ? ~w_mag : w_mag;
    assign w_neg = w_dneg;
  end else begin : g_binary
    logic w_bit;
    logic w_msb;

    // In signed mode the top multiplier bit carries negative weight.
    assign w_bit = w_gx[w_gidx];
    assign w_msb = SIGNED && (w_gidx == IW'(W - 1));
    assign w_pp  = w_bit ? (w_msb ? ~w_ye : w_ye) : '0;
    assign w_neg = w_bit && w_msb;
  end

  // Next-state and registered-output computation; everything holds by default.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    pp_d    = pp_q;
    neg_d   = neg_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (w_accept) begin
      x_d = strm.in_x;
      y_d = strm.in_y;
    end
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d = ST_EMIT;
          valid_d = 1'b1;
          pp_d    = w_pp;
          neg_d   = w_neg;
          idx_d   = w_gidx;
          last_d  = w_glast;
        end
      end
      ST_EMIT: begin
        if (w_fire) begin
          if (!last_q || w_accept) begin
            valid_d = 1'b1;
            pp_d    = w_pp;
            neg_d   = w_neg;
            idx_d   = w_gidx;
            last_d  = w_glast;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            pp_d    = '0;
            neg_d   = 1'b0;
            idx_d   = '0;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any stream in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      pp_q    <= '0;
      neg_q   <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      pp_q    <= pp_d;
      neg_q   <= neg_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign strm.in_ready = w_in_ready;
  assign strm.pp_valid = valid_q;
  assign strm.pp       = pp_q;
  assign strm.pp_neg   = neg_q;
  assign strm.pp_idx   = idx_q;
  assign strm.pp_last  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_pp_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pp_stream_gen
//  Purpose  : Self-checking bench for pp_stream_gen with W=8 in all four
//             configurations (index c = {RADIX4, SIGNED}).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pp_stream_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] tv;
  logic [3:0] tr;
  logic [7:0] tx [4];
  logic [7:0] ty [4];
  wire  [3:0] ov;
  wire  [3:0] ordy;
  wire  [3:0] oneg;
  wire  [3:0] olast;
  wire  [9:0] opp  [4];
  wire  [2:0] oidx [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] pp;
    logic       neg;
    int         idx;
    logic       last;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] opx [$];
  logic [7:0] opy [$];
  int         prod_q [$];
  logic [9:0] obs_pp  [8];
  logic       obs_neg [8];
  int         cyc_used;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam bit R4  = (k >= 2);
    localparam bit SG  = (k % 2 == 1);
    localparam int NP  = R4 ? (SG ? 4 : 5) : 8;
    localparam int IWK = (NP > 1) ? $clog2(NP) : 1;

    pp_stream_gen_if #(.W(8), .IW(IWK)) u_if ();

    pp_stream_gen #(.W(8), .RADIX4(R4), .SIGNED(SG)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .strm (u_if.slave)
    );

    assign u_if.in_valid = tv[k];
    assign u_if.in_x     = tx[k];
    assign u_if.in_y     = ty[k];
    assign u_if.pp_ready = tr[k];
    assign ov[k]         = u_if.pp_valid;
    assign ordy[k]       = u_if.in_ready;
    assign oneg[k]       = u_if.pp_neg;
    assign olast[k]      = u_if.pp_last;
    assign opp[k]        = u_if.pp;
    assign oidx[k]       = 3'(u_if.pp_idx);
  end

  function automatic int npp(input int c);
    return (c < 2) ? 8 : ((c == 3) ? 4 : 5);
  endfunction

  // Reference: signed digit value d times extended Y, encoded as ~|d*Y| + 1 when negative.
  function automatic void model(input int c, input logic [7:0] x, input logic [7:0] y,
                                input int i, output logic [9:0] pp, output logic neg);
    int ye, xe, d, j;
    ye = c[0] ? int'($signed(y)) : int'(y);
    if (c < 2) begin
      d = int'(x[i]);
      if (c == 1 && i == 7) d = -d;
    end else begin
      xe = c[0] ? int'($signed(x)) : int'(x);
      j  = 2 * i;
      d  = -2 * int'(xe[j+1]) + int'(xe[j]) + ((i == 0) ? 0 : int'(xe[j-1]));
    end
    if (d < 0) begin
      pp  = ~10'(-d * ye);
      neg = 1'b1;
    end else begin
      pp  = 10'(d * ye);
      neg = 1'b0;
    end
  endfunction

  function automatic int product(input int c, input logic [7:0] x, input logic [7:0] y);
    return c[0] ? int'($signed(x)) * int'($signed(y)) : int'(x) * int'(y);
  endfunction

  // Drives queued operand pairs into config c and scores the resulting stream.
  task automatic run_stream(input int c, input int stall_idx, input int stall_n);
    int   stalled = 0;
    int   acc = 0;
    int   n = 0;
    int   p;
    bit   done = 1'b0;
    exp_t e;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      tv[c] = (opx.size() > 0);
      if (opx.size() > 0) begin
        tx[c] = opx[0];
        ty[c] = opy[0];
      end
      if (ov[c] && int'(oidx[c]) == stall_idx && stalled < stall_n) begin
        tr[c] = 1'b0;
        stalled++;
      end else begin
        tr[c] = 1'b1;
      end
      #1;
      if (!tr[c]) begin
        checks++;
        if (ov[c] !== 1'b1 || sb.size() == 0 || ordy[c] !== 1'b0 ||
            opp[c] !== sb[0].pp || oneg[c] !== sb[0].neg || int'(oidx[c]) != sb[0].idx) begin
          errors++;
          $display("FAIL stall_hold c=%0d got valid=%b pp=%h idx=%0d in_ready=%b, expected held pp of idx=%0d",
                   c, ov[c], opp[c], oidx[c], ordy[c], (sb.size() > 0) ? sb[0].idx : -1);
        end
      end
      if (tv[c] && ordy[c]) begin
        for (int i = 0; i < npp(c); i++) begin
          model(c, opx[0], opy[0], i, e.pp, e.neg);
          e.idx  = i;
          e.last = (i == npp(c) - 1);
          sb.push_back(e);
        end
        prod_q.push_back(product(c, opx[0], opy[0]));
        void'(opx.pop_front());
        void'(opy.pop_front());
      end
      if (ov[c] && tr[c]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pp_unexpected c=%0d got pp=%h idx=%0d, expected no pp", c, opp[c], oidx[c]);
        end else begin
          e = sb.pop_front();
          if (opp[c] !== e.pp || oneg[c] !== e.neg || int'(oidx[c]) != e.idx || olast[c] !== e.last) begin
            errors++;
            $display("FAIL pp c=%0d got pp=%h neg=%b idx=%0d last=%b, expected pp=%h neg=%b idx=%0d last=%b",
                     c, opp[c], oneg[c], oidx[c], olast[c], e.pp, e.neg, e.idx, e.last);
          end
          obs_pp[e.idx]  = opp[c];
          obs_neg[e.idx] = oneg[c];
          acc += (int'($signed(opp[c])) + int'(oneg[c])) <<< (e.idx * ((c >= 2) ? 2 : 1));
          if (e.last) begin
            p = prod_q.pop_front();
            checks++;
            if (acc[15:0] !== p[15:0] || ordy[c] !== 1'b1) begin
              errors++;
              $display("FAIL sum c=%0d got sum=%h in_ready=%b, expected sum=%h in_ready=1",
                       c, acc[15:0], ordy[c], p[15:0]);
            end
            acc = 0;
          end
        end
      end
      if (opx.size() == 0 && sb.size() == 0) done = 1'b1;
    end
    cyc_used = n;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout c=%0d got %0d pps outstanding, expected 0", c, sb.size());
      sb.delete();
      opx.delete();
      opy.delete();
      prod_q.delete();
    end
  endtask

  task automatic push_op(input logic [7:0] x, input logic [7:0] y);
    opx.push_back(x);
    opy.push_back(y);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (ov[c] !== 1'b0 || opp[c] !== 10'h000 || oidx[c] !== 3'd0 || olast[c] !== 1'b0 ||
          oneg[c] !== 1'b0 || ordy[c] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state c=%0d got valid=%b pp=%h idx=%0d last=%b neg=%b in_ready=%b, expected 0/0/0/0/0/1",
                 c, ov[c], opp[c], oidx[c], olast[c], oneg[c], ordy[c]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_binary_unsigned();
    push_op(8'h05, 8'hFF);
    run_stream(0, -1, 0);
    checks++;
    if (obs_pp[0] !== 10'h0FF || obs_pp[2] !== 10'h0FF || obs_pp[1] !== 10'h000 ||
        obs_pp[7] !== 10'h000 || cyc_used != 9) begin
      errors++;
      $display("FAIL bin_u_values got pp0=%h pp1=%h pp2=%h pp7=%h cycles=%0d, expected 0ff/000/0ff/000 cycles=9",
               obs_pp[0], obs_pp[1], obs_pp[2], obs_pp[7], cyc_used);
    end
  endtask

  task automatic test_radix4_signed();
    push_op(8'h07, 8'h03);
    run_stream(3, -1, 0);
    checks++;
    if (obs_pp[0] !== 10'h3FC || obs_neg[0] !== 1'b1 || obs_pp[1] !== 10'h006 ||
        obs_neg[1] !== 1'b0 || obs_pp[2] !== 10'h000 || obs_pp[3] !== 10'h000) begin
      errors++;
      $display("FAIL r4_s_7x3 got pp0=%h neg0=%b pp1=%h pp2=%h pp3=%h, expected 3fc/1/006/000/000",
               obs_pp[0], obs_neg[0], obs_pp[1], obs_pp[2], obs_pp[3]);
    end
    push_op(8'h02, 8'h80);
    run_stream(3, -1, 0);
    checks++;
    if (obs_pp[0] !== 10'h0FF || obs_neg[0] !== 1'b1) begin
      errors++;
      $display("FAIL r4_s_2x80 got pp0=%h neg0=%b, expected 0ff/1", obs_pp[0], obs_neg[0]);
    end
  endtask

  task automatic test_binary_signed();
    push_op(8'h80, 8'h03);
    run_stream(1, -1, 0);
    checks++;
    if (obs_pp[7] !== 10'h3FC || obs_neg[7] !== 1'b1 || obs_pp[0] !== 10'h000 || obs_pp[6] !== 10'h000) begin
      errors++;
      $display("FAIL bin_s_msb got pp7=%h neg7=%b pp0=%h pp6=%h, expected 3fc/1/000/000",
               obs_pp[7], obs_neg[7], obs_pp[0], obs_pp[6]);
    end
  endtask

  task automatic test_radix4_unsigned();
    push_op(8'hFF, 8'h01);
    run_stream(2, -1, 0);
    checks++;
    if (obs_pp[0] !== 10'h3FE || obs_neg[0] !== 1'b1 || obs_pp[1] !== 10'h000 ||
        obs_pp[4] !== 10'h001 || obs_neg[4] !== 1'b0 || cyc_used != 6) begin
      errors++;
      $display("FAIL r4_u_ff got pp0=%h neg0=%b pp1=%h pp4=%h neg4=%b cycles=%0d, expected 3fe/1/000/001/0 cycles=6",
               obs_pp[0], obs_neg[0], obs_pp[1], obs_pp[4], obs_neg[4], cyc_used);
    end
  endtask

  task automatic test_back_to_back();
    push_op(8'h5A, 8'hC3);
    push_op(8'h81, 8'h7F);
    run_stream(3, 1, 3);
    checks++;
    if (cyc_used != 12) begin
      errors++;
      $display("FAIL back_to_back_cycles got %0d, expected 12", cyc_used);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    @(negedge clk);
    tv[3] = 1'b1;
    tx[3] = 8'h6B;
    ty[3] = 8'h95;
    tr[3] = 1'b1;
    @(negedge clk);
    tv[3] = 1'b0;
    while (!(ov[3] && oidx[3] == 3'd2) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(ov[3] && oidx[3] == 3'd2)) begin
      errors++;
      $display("FAIL abort_reach got valid=%b idx=%0d, expected valid=1 idx=2", ov[3], oidx[3]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ov[3] !== 1'b0 || ordy[3] !== 1'b1) begin
      errors++;
      $display("FAIL abort_reset got valid=%b in_ready=%b, expected 0/1", ov[3], ordy[3]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ov[3] !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet got valid=%b, expected 0", ov[3]);
    end
    push_op(8'h13, 8'hF1);
    run_stream(3, -1, 0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 4; c++) begin
      push_op(8'h80, 8'h80);
      push_op(8'hFF, 8'hFF);
      push_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      push_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      run_stream(c, -1, 0);
      checks++;
      if (cyc_used != 1 + 4 * npp(c)) begin
        errors++;
        $display("FAIL random_cycles c=%0d got %0d, expected %0d", c, cyc_used, 1 + 4 * npp(c));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    tv  = '0;
    tr  = '0;
    for (int c = 0; c < 4; c++) begin
      tx[c] = '0;
      ty[c] = '0;
    end
    test_reset();
    test_binary_unsigned();
    test_radix4_signed();
    test_binary_signed();
    test_radix4_unsigned();
    test_back_to_back();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
